// File: rtl/pcm_pkg.sv
// Shared types for the PCM transmitter scheduler: FSM states, profile field widths and the
// per-requester frame profile record.
package pcm_pkg;

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CODE_W = 32;
    localparam int unsigned NUM_W  = 2;
    localparam int unsigned PAT_W  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StStart,
        StWait,
        StGap
    } pcm_state_t;

    typedef struct packed {
        logic [BAUD_W-1:0] baudrate;
        logic [LEN_W-1:0]  length;
        logic [CODE_W-1:0] code;
        logic [NUM_W-1:0]  number;
        logic [PAT_W-1:0]  pattern;
        logic              edge_sel;
    } pcm_profile_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcm_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping to 0.
module pcm_rr_arbiter import pcm_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o                  = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
                gnt_o[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcm_tx_scheduler.sv
// Round-robin scheduler sharing one PCM transmitter chain between N_REQ requesters.
// Optional watchdog in WAIT is enabled by defining PCM_SCHED_WDOG_EN.
module pcm_tx_scheduler import pcm_pkg::*; #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned WDOG_CYCLES = 2**20
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [BAUD_W*N_REQ-1:0]  baudrate_i,
    input  logic [LEN_W*N_REQ-1:0]   length_i,
    input  logic [CODE_W*N_REQ-1:0]  code_i,
    input  logic [NUM_W*N_REQ-1:0]   number_i,
    input  logic [PAT_W*N_REQ-1:0]   pattern_i,
    input  logic [N_REQ-1:0]         edge_i,
    input  logic                     tx_done_i,
    output logic                     tx_start_o,
    output logic [BAUD_W-1:0]        tx_baudrate_o,
    output logic [LEN_W-1:0]         tx_length_o,
    output logic [CODE_W-1:0]        tx_code_o,
    output logic [NUM_W-1:0]         tx_number_o,
    output logic [PAT_W-1:0]         tx_pattern_o,
    output logic                     tx_edge_o,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned IdxW = idx_w(N_REQ);
    localparam int unsigned GapW = idx_w(GAP_CYCLES + 1);

    pcm_state_t       state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d, win_q, win_d, next_ptr;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [GapW-1:0]  gap_q, gap_d;
    pcm_profile_t     prof_q, prof_d, sel_prof;
    logic [N_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]  arb_idx;
    logic             arb_valid;
    logic             frame_end;

    pcm_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        sel_prof.baudrate = baudrate_i[32'(arb_idx)*BAUD_W +: BAUD_W];
        sel_prof.length   = length_i[32'(arb_idx)*LEN_W +: LEN_W];
        sel_prof.code     = code_i[32'(arb_idx)*CODE_W +: CODE_W];
        sel_prof.number   = number_i[32'(arb_idx)*NUM_W +: NUM_W];
        sel_prof.pattern  = pattern_i[32'(arb_idx)*PAT_W +: PAT_W];
        sel_prof.edge_sel = edge_i[arb_idx];
    end

    assign next_ptr = (win_q == IdxW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef PCM_SCHED_WDOG_EN
    localparam int unsigned WdogW = idx_w(WDOG_CYCLES + 1);

    logic [WdogW-1:0] wdog_q;
    logic             err_q;
    logic             wdog_hit;

    assign wdog_hit = (state_q == StWait) && !tx_done_i &&
                      (wdog_q == WdogW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= (state_q == StWait) ? wdog_q + 1'b1 : '0;
            if (wdog_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign frame_end = tx_done_i || wdog_hit;
    assign err_o     = err_q;
`else
    logic unused_wdog;

    assign unused_wdog = ^WDOG_CYCLES;
    assign frame_end   = tx_done_i;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        gap_d   = gap_q;
        prof_d  = prof_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                // Profile and grant are latched here so they are valid throughout LOAD.
                if (arb_valid) begin
                    state_d = StLoad;
                    win_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    prof_d  = sel_prof;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                if (frame_end) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            gap_q   <= '0;
            prof_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
            prof_q  <= prof_d;
        end
    end

    assign tx_start_o    = (state_q == StStart);
    assign busy_o        = (state_q != StIdle);
    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign tx_baudrate_o = prof_q.baudrate;
    assign tx_length_o   = prof_q.length;
    assign tx_code_o     = prof_q.code;
    assign tx_number_o   = prof_q.number;
    assign tx_pattern_o  = prof_q.pattern;
    assign tx_edge_o     = prof_q.edge_sel;

endmodule
